// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch sequencer and its ROMs.
package fetch_pkg;

    localparam int unsigned FETCH_A          = 10;
    localparam int unsigned FETCH_LW         = 5;
    localparam int unsigned FETCH_CW         = 16;
    localparam int unsigned FETCH_START_ADDR = 0;
    localparam int unsigned FETCH_LUT_DEPTH  = 2 ** FETCH_LW;
    localparam int unsigned FETCH_LUT_W      = FETCH_LUT_DEPTH * FETCH_A;

    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

    // Default branch-target image, entry i at bits [i*A +: A]; same layout as branch_targets.
    localparam logic [FETCH_LUT_W-1:0] FETCH_LUT_INIT =
          FETCH_LUT_W'(10'd100)
        | (FETCH_LUT_W'(10'h3FE) << FETCH_A)
        | (FETCH_LUT_W'(10'd5)   << (2 * FETCH_A));

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target LUT: maps a short instruction index to an A-bit target/offset.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int unsigned A = FETCH_A,
    parameter int unsigned LW = FETCH_LW,
    parameter logic [(2**LW)*A-1:0] INIT = FETCH_LUT_INIT
) (
    input  logic [LW-1:0] idx,
    output logic [A-1:0]  target_c
);

    localparam int unsigned DEPTH = 2 ** LW;

    logic [A-1:0] lut [DEPTH];

    // Unpack the flat contents image into the lookup table.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            lut[i] = INIT[i*A +: A];
        end
    end

    assign target_c = lut[idx];

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: start/done handshake, stalls, halts and LUT-based branches.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned A = FETCH_A,
    parameter int unsigned LW = FETCH_LW,
    parameter int unsigned START_ADDR = FETCH_START_ADDR,
    parameter int unsigned CW = FETCH_CW,
    parameter logic [(2**LW)*A-1:0] LUT_INIT = FETCH_LUT_INIT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          halt,
    input  logic          branch_en,
    input  logic          branch_rel,
    input  logic [LW-1:0] branch_idx,
    output logic [A-1:0]  inst_addr,
    output logic          fetch_valid,
    output logic          done,
    output logic [CW-1:0] cycle_count
);

    fetch_state_t  state_q, state_d;
    logic [A-1:0]  pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [A-1:0]  lut_target;

    branch_lut #(
        .A    (A),
        .LW   (LW),
        .INIT (LUT_INIT)
    ) u_branch_lut (
        .idx      (branch_idx),
        .target_c (lut_target)
    );

    // Next state, next PC and run counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = A'(START_ADDR);
                    count_d = '0;
                end
            end
            RUN: begin
                if (count_q != {CW{1'b1}}) begin
                    count_d = count_q + CW'(1);
                end
                // Relative offsets are two's complement, so a plain modular add covers them.
                if (stall) begin
                    pc_d = pc_q;
                end else if (halt) begin
                    state_d = HALT;
                end else if (branch_en) begin
                    pc_d = branch_rel ? (pc_q + lut_target) : lut_target;
                end else begin
                    pc_d = pc_q + A'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign inst_addr   = pc_q;
    assign fetch_valid = (state_q == RUN);
    assign done        = (state_q == HALT);
    assign cycle_count = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_ctrl;

    localparam int unsigned TA    = 10;
    localparam int unsigned TLW   = 5;
    localparam int unsigned TCW   = 8;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned LUTW  = DEPTH * TA;

    localparam logic [LUTW-1:0] TB_LUT =
          LUTW'(10'd100)
        | (LUTW'(10'h3FE) << TA)
        | (LUTW'(10'd5)   << (2 * TA))
        | (LUTW'(10'h3FF) << (3 * TA))
        | (LUTW'(10'h3F0) << (4 * TA))
        | (LUTW'(10'd17)  << (5 * TA))
        | (LUTW'(10'd512) << (6 * TA));

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, stall = 1'b0, halt = 1'b0;
    logic branch_en = 1'b0, branch_rel = 1'b0;
    logic [TLW-1:0] branch_idx = '0;
    logic [TA-1:0]  inst_addr;
    logic           fetch_valid, done;
    logic [TCW-1:0] cycle_count;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model: running/finished flags, PC and run-cycle count as integers.
    bit m_run, m_done;
    int m_pc, m_cnt;
    int lut_m [DEPTH];

    always #5 clk = ~clk;

    fetch_ctrl #(
        .A          (TA),
        .LW         (TLW),
        .START_ADDR (0),
        .CW         (TCW),
        .LUT_INIT   (TB_LUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .halt        (halt),
        .branch_en   (branch_en),
        .branch_rel  (branch_rel),
        .branch_idx  (branch_idx),
        .inst_addr   (inst_addr),
        .fetch_valid (fetch_valid),
        .done        (done),
        .cycle_count (cycle_count)
    );

    task automatic model_update();
        int off;
        if (reset) begin
            m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
            end
        end else begin
            if (m_cnt < (1 << TCW) - 1) m_cnt++;
            if (stall) begin
                // hold
            end else if (halt) begin
                m_run = 0; m_done = 1;
            end else if (branch_en) begin
                if (branch_rel) begin
                    off  = (lut_m[branch_idx] >= 512) ? lut_m[branch_idx] - 1024 : lut_m[branch_idx];
                    m_pc = (m_pc + off + 1024) % 1024;
                end else begin
                    m_pc = lut_m[branch_idx];
                end
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; start = 0; stall = 0; halt = 0;
        branch_en = 0; branch_rel = 0; branch_idx = '0;
    endtask

    task automatic do_reset_start();
        clear_inputs();
        reset = 1; step();
        reset = 0; start = 1; step();
        start = 0;
    endtask

    task automatic test_reset();
        reset = 1; step(); step();
        n_total++;
        if ({inst_addr, fetch_valid, done, cycle_count} !== {10'd0, 1'b0, 1'b0, 8'd0})
            $display("FAIL reset: got pc=%0d v=%b d=%b cnt=%0d, want 0/0/0/0",
                     inst_addr, fetch_valid, done, cycle_count);
        else n_pass++;
    endtask

    task automatic test_sequential();
        reset = 0; start = 1; step(); start = 0;
        n_total++;
        if ({inst_addr, fetch_valid, done, cycle_count} !== {10'd0, 1'b1, 1'b0, 8'd0})
            $display("FAIL start_latency: got pc=%0d v=%b d=%b cnt=%0d, want 0/1/0/0",
                     inst_addr, fetch_valid, done, cycle_count);
        else n_pass++;
        repeat (4) step();
        n_total++;
        if ({inst_addr, cycle_count} !== {10'd4, 8'd4})
            $display("FAIL seq4: got pc=%0d cnt=%0d, want pc=4 cnt=4", inst_addr, cycle_count);
        else n_pass++;
    endtask

    task automatic test_branch();
        do_reset_start();
        repeat (3) step();
        branch_en = 1; branch_rel = 0; branch_idx = 5'd0; step();
        n_total++;
        if (inst_addr !== 10'd100)
            $display("FAIL branch_abs: got pc=%0d, want 100", inst_addr);
        else n_pass++;
        branch_rel = 1; branch_idx = 5'd1; step();
        n_total++;
        if (inst_addr !== 10'd98)
            $display("FAIL branch_rel_neg: got pc=%0d, want 98", inst_addr);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_stall_halt();
        int c0;
        do_reset_start();
        repeat (7) step();
        c0 = int'(cycle_count);
        stall = 1; halt = 1; branch_en = 1;
        repeat (3) step();
        n_total++;
        if ({inst_addr, fetch_valid, done} !== {10'd7, 1'b1, 1'b0} || int'(cycle_count) != c0 + 3)
            $display("FAIL stall_hold: got pc=%0d v=%b d=%b cnt=%0d, want pc=7 v=1 d=0 cnt=%0d",
                     inst_addr, fetch_valid, done, cycle_count, c0 + 3);
        else n_pass++;
        stall = 0; branch_en = 0; step();
        halt = 0;
        n_total++;
        if ({inst_addr, fetch_valid, done} !== {10'd7, 1'b0, 1'b1})
            $display("FAIL halt_done: got pc=%0d v=%b d=%b, want pc=7 v=0 d=1",
                     inst_addr, fetch_valid, done);
        else n_pass++;
        step(); step();
        n_total++;
        if ({inst_addr, done, cycle_count} !== {10'd7, 1'b1, 8'(c0 + 4)})
            $display("FAIL halt_hold: got pc=%0d d=%b cnt=%0d, want pc=7 d=1 cnt=%0d",
                     inst_addr, done, cycle_count, c0 + 4);
        else n_pass++;
    endtask

    task automatic test_restart();
        start = 1; step(); start = 0;
        n_total++;
        if ({inst_addr, fetch_valid, done, cycle_count} !== {10'd0, 1'b1, 1'b0, 8'd0})
            $display("FAIL restart: got pc=%0d v=%b d=%b cnt=%0d, want 0/1/0/0",
                     inst_addr, fetch_valid, done, cycle_count);
        else n_pass++;
        start = 1; step(); step(); start = 0;
        n_total++;
        if ({inst_addr, fetch_valid, cycle_count} !== {10'd2, 1'b1, 8'd2})
            $display("FAIL start_in_run: got pc=%0d v=%b cnt=%0d, want pc=2 v=1 cnt=2",
                     inst_addr, fetch_valid, cycle_count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset_start();
        branch_en = 1; branch_rel = 0; branch_idx = 5'd3; step();
        branch_en = 0;
        n_total++;
        if (inst_addr !== 10'd1023)
            $display("FAIL goto_top: got pc=%0d, want 1023", inst_addr);
        else n_pass++;
        step();
        n_total++;
        if (inst_addr !== 10'd0)
            $display("FAIL pc_wrap: got pc=%0d, want 0", inst_addr);
        else n_pass++;
        branch_en = 1; branch_rel = 1; branch_idx = 5'd1; step();
        clear_inputs();
        n_total++;
        if (inst_addr !== 10'd1022)
            $display("FAIL rel_wrap: got pc=%0d, want 1022", inst_addr);
        else n_pass++;
    endtask

    task automatic test_saturate();
        do_reset_start();
        stall = 1;
        repeat (300) step();
        stall = 0;
        n_total++;
        if ({inst_addr, fetch_valid, cycle_count} !== {10'd0, 1'b1, 8'd255})
            $display("FAIL count_sat: got pc=%0d v=%b cnt=%0d, want pc=0 v=1 cnt=255",
                     inst_addr, fetch_valid, cycle_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        do_reset_start();
        repeat (50) step();
        n_total++;
        if (inst_addr !== 10'd50)
            $display("FAIL reach50: got pc=%0d, want 50", inst_addr);
        else n_pass++;
        reset = 1; step();
        n_total++;
        if ({inst_addr, fetch_valid, done, cycle_count} !== {10'd0, 1'b0, 1'b0, 8'd0})
            $display("FAIL reset_mid_run: got pc=%0d v=%b d=%b cnt=%0d, want 0/0/0/0",
                     inst_addr, fetch_valid, done, cycle_count);
        else n_pass++;
        start = 1; step();
        reset = 0; start = 0; step();
        n_total++;
        if ({inst_addr, fetch_valid, done} !== {10'd0, 1'b0, 1'b0})
            $display("FAIL reset_beats_start: got pc=%0d v=%b d=%b, want 0/0/0",
                     inst_addr, fetch_valid, done);
        else n_pass++;
    endtask

    task automatic test_random();
        clear_inputs();
        reset = 1; step(); reset = 0;
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            start      = ($urandom_range(0, 9) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            halt       = ($urandom_range(0, 24) == 0);
            branch_en  = ($urandom_range(0, 3) == 0);
            branch_rel = 1'($urandom_range(0, 1));
            branch_idx = TLW'($urandom_range(0, 7));
            step();
            n_total++;
            if ({inst_addr, fetch_valid, done, cycle_count} !==
                {TA'(m_pc), m_run, m_done, TCW'(m_cnt)})
                $display("FAIL random cyc %0d: got pc=%0d v=%b d=%b cnt=%0d, want pc=%0d v=%b d=%b cnt=%0d",
                         i, inst_addr, fetch_valid, done, cycle_count, m_pc, m_run, m_done, m_cnt);
            else n_pass++;
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) lut_m[i] = 0;
        lut_m[0] = 100; lut_m[1] = 10'h3FE; lut_m[2] = 5; lut_m[3] = 10'h3FF;
        lut_m[4] = 10'h3F0; lut_m[5] = 17; lut_m[6] = 512;
        m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;

        test_reset();
        test_sequential();
        test_branch();
        test_stall_halt();
        test_restart();
        test_wrap();
        test_saturate();
        test_reset_mid_run();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
